pipelined_subtractor: RTL and testbench

Parametrised, pipelined two's-complement subtractor for the datapath ALU. Splits a WIDTH-bit operation into STAGES equal chunks, with the borrow chain registered between chunks to shorten the critical path. Supports ARMv4 SUB/SBC/RSB/RSC modes and produces NZCV flags. Uses valid/ready handshakes on both sides, with full-pipeline stall on backpressure.

---
 rtl/pipelined_subtractor.sv | 127 ++++++++++++
 tb/tb_pipelined_subtractor.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_subtractor.sv
// Pipelined two's-complement subtractor (SUB/SBC/RSB/RSC) with a registered borrow chain and NZCV flags.
// Optional SUB_SATURATE_EN adds in_sat: signed saturation of the result on overflow.
module pipelined_subtractor #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_mode,
    input  logic             in_cin,
`ifdef SUB_SATURATE_EN
    input  logic             in_sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_r,
    output logic [3:0]       out_flags
);
    localparam int CHUNK = WIDTH / STAGES;
    localparam int L     = STAGES - 1;
    localparam int PS    = (STAGES > 1) ? STAGES - 1 : 1;

    if (STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_param_chk
        $error("pipelined_subtractor: WIDTH must be a non-zero multiple of STAGES");
    end

    // Inter-stage registers: slot k feeds stage k+1.
    logic [PS-1:0]    vld_q;
    logic [PS-1:0]    b_q;
    logic [PS-1:0]    sat_q;
    logic [WIDTH-1:0] x_q [PS];
    logic [WIDTH-1:0] y_q [PS];
    logic [WIDTH-1:0] r_q [PS];

    logic             out_valid_q;
    logic [WIDTH-1:0] out_r_q;
    logic [3:0]       flags_q;

    // Per-stage inputs (_s) and computed next values (_d).
    logic [WIDTH-1:0] x_s [STAGES];
    logic [WIDTH-1:0] y_s [STAGES];
    logic [WIDTH-1:0] r_s [STAGES];
    logic [WIDTH-1:0] r_d [STAGES];
    logic [STAGES-1:0] v_s, b_s, s_s, b_d;

    logic             sat_in;
    logic             en;
    logic             ovf;
    logic [WIDTH-1:0] res_d;
    logic [3:0]       flags_d;

`ifdef SUB_SATURATE_EN
    assign sat_in = in_sat;
`else
    assign sat_in = 1'b0;
`endif

    assign en        = !out_valid_q || out_ready;
    assign in_ready  = en;
    assign out_valid = out_valid_q;
    assign out_r     = out_r_q;
    assign out_flags = flags_q;

    always_comb begin
        logic [CHUNK:0] diff;
        diff   = '0;
        // Reverse modes swap operands at entry; carry-using modes borrow !cin.
        x_s[0] = in_mode[1] ? in_b : in_a;
        y_s[0] = in_mode[1] ? in_a : in_b;
        r_s[0] = '0;
        v_s[0] = in_valid;
        b_s[0] = in_mode[0] & ~in_cin;
        s_s[0] = sat_in;
        for (int k = 1; k < STAGES; k++) begin
            x_s[k] = x_q[k-1];
            y_s[k] = y_q[k-1];
            r_s[k] = r_q[k-1];
            v_s[k] = vld_q[k-1];
            b_s[k] = b_q[k-1];
            s_s[k] = sat_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            diff = {1'b0, x_s[k][k*CHUNK +: CHUNK]} - {1'b0, y_s[k][k*CHUNK +: CHUNK]}
                 - {{CHUNK{1'b0}}, b_s[k]};
            r_d[k] = r_s[k];
            r_d[k][k*CHUNK +: CHUNK] = diff[CHUNK-1:0];
            b_d[k] = diff[CHUNK];
        end
    end

    // Flags come from the unsaturated difference except N/Z, which track the delivered value.
    assign ovf   = (x_s[L][WIDTH-1] != y_s[L][WIDTH-1]) && (r_d[L][WIDTH-1] != x_s[L][WIDTH-1]);
    assign res_d = (s_s[L] && ovf) ? (x_s[L][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                      : {1'b0, {(WIDTH-1){1'b1}}})
                                   : r_d[L];
    assign flags_d = {res_d[WIDTH-1], (res_d == '0), ~b_d[L], ovf};

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q       <= '0;
            out_valid_q <= 1'b0;
            out_r_q     <= '0;
            flags_q     <= '0;
        end else if (en) begin
            for (int k = 0; k < L; k++) vld_q[k] <= v_s[k];
            out_valid_q <= v_s[L];
            out_r_q     <= res_d;
            flags_q     <= flags_d;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            for (int k = 0; k < L; k++) begin
                x_q[k]   <= x_s[k];
                y_q[k]   <= y_s[k];
                r_q[k]   <= r_d[k];
                b_q[k]   <= b_d[k];
                sat_q[k] <= s_s[k];
            end
        end
    end
endmodule

// File: tb/tb_pipelined_subtractor.sv
// Bench for pipelined_subtractor: three depths (4, 1, 8) driven by shared stimulus, each
// checked every cycle against a full-width reference model with a stall-aware FIFO scoreboard.
module tb_pipelined_subtractor;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_a = '0;
    logic [W-1:0]  in_b = '0;
    logic [1:0]    in_mode = '0;
    logic          in_cin = 1'b0;
    logic          out_ready = 1'b1;
`ifdef SUB_SATURATE_EN
    logic          in_sat = 1'b0;
`endif
    logic          sat_eff;
    logic [2:0]    in_ready_w;
    logic [2:0]    out_valid_w;
    logic [W-1:0]  out_r_w [3];
    logic [3:0]    out_flags_w [3];

    int checks = 0;
    int errors = 0;
    int xfer_cnt [3] = '{0, 0, 0};
    int qlen [3] = '{0, 0, 0};

`ifdef SUB_SATURATE_EN
    assign sat_eff = in_sat;
`else
    assign sat_eff = 1'b0;
`endif

    always #5 clk = ~clk;

    // Whole-word reference: {result, N, Z, C, V}.
    function automatic logic [W+3:0] ref_op(logic [W-1:0] a, logic [W-1:0] b,
                                            logic [1:0] mode, logic cin, logic sat);
        logic [W-1:0] x, y, r;
        logic [W:0]   full;
        logic         c, v;
        x    = mode[1] ? b : a;
        y    = mode[1] ? a : b;
        full = {1'b0, x} - {1'b0, y} - ((mode[0] && !cin) ? 33'd1 : 33'd0);
        r    = full[W-1:0];
        c    = !full[W];
        v    = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
        if (sat && v) r = x[W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        return {r, r[W-1], (r == '0), c, v};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int S = (g == 0) ? 4 : ((g == 1) ? 1 : 8);
        typedef struct packed { logic [W+3:0] exp; int stamp; } ent_t;
        ent_t q [$];
        int   ecnt = 0;
        bit   rst_prev = 1'b0;

        pipelined_subtractor #(.WIDTH(W), .STAGES(S)) dut (
            .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_w[g]),
            .in_a(in_a), .in_b(in_b), .in_mode(in_mode), .in_cin(in_cin),
`ifdef SUB_SATURATE_EN
            .in_sat(in_sat),
`endif
            .out_valid(out_valid_w[g]), .out_ready(out_ready),
            .out_r(out_r_w[g]), .out_flags(out_flags_w[g]));

        // An op is visible once it has seen S advancing edges; stalls freeze everyone's age.
        always @(posedge clk) begin : mdl
            bit m;
            m = (q.size() != 0) && (ecnt - q[0].stamp >= S);
            rst_prev = reset;
            if (reset) q.delete();
            else begin
                if (m && out_ready) void'(q.pop_front());
                if (!m || out_ready) begin
                    ecnt++;
                    if (in_valid) q.push_back('{ref_op(in_a, in_b, in_mode, in_cin, sat_eff), ecnt - 1});
                end
            end
            qlen[g] = q.size();
        end

        always @(negedge clk) begin : cmp
            bit m;
            logic [W+3:0] e;
            m = (q.size() != 0) && (ecnt - q[0].stamp >= S);
            checks++;
            if (out_valid_w[g] !== m) begin
                errors++;
                $display("FAIL out_valid S=%0d t=%0t got %b exp %b", S, $time, out_valid_w[g], m);
            end
            checks++;
            if (in_ready_w[g] !== (!m || out_ready)) begin
                errors++;
                $display("FAIL in_ready S=%0d t=%0t got %b exp %b", S, $time, in_ready_w[g], !m || out_ready);
            end
            if (rst_prev) begin
                checks++;
                if ({out_r_w[g], out_flags_w[g]} !== '0) begin
                    errors++;
                    $display("FAIL reset_state S=%0d got %h/%b exp 0/0000", S, out_r_w[g], out_flags_w[g]);
                end
            end else if (m) begin
                e = q[0].exp;
                checks++;
                if ({out_r_w[g], out_flags_w[g]} !== e) begin
                    errors++;
                    $display("FAIL result S=%0d t=%0t got %h/%b exp %h/%b", S, $time,
                             out_r_w[g], out_flags_w[g], e[W+3:4], e[3:0]);
                end
            end
            if (out_valid_w[g] === 1'b1 && out_ready) xfer_cnt[g]++;
        end
    end

    task automatic chk(string name, logic [W+3:0] got, logic [W+3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h/%b exp %h/%b", name, got[W+3:4], got[3:0], exp[W+3:4], exp[3:0]);
        end
    endtask

    // One op on an idle pipe; depth-4 result must show exactly 4 cycles after accept.
    task automatic directed(string name, logic [W-1:0] a, logic [W-1:0] b, logic [1:0] mode,
                            logic cin, logic [W-1:0] er, logic [3:0] ef);
        int n;
        out_ready = 1'b1;
        in_valid = 1'b1; in_a = a; in_b = b; in_mode = mode; in_cin = cin;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (n < 12) begin
            @(negedge clk);
            n++;
            if (out_valid_w[0]) break;
        end
        checks++;
        if (n != 4 || !out_valid_w[0]) begin
            errors++;
            $display("FAIL %s latency got %0d exp 4", name, n);
        end
        chk(name, {out_r_w[0], out_flags_w[0]}, {er, ef});
        @(posedge clk); #1;
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0000_0000;
            1: return 32'h8000_0000;
            2: return 32'h7FFF_FFFF;
            3: return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int start, c, guard;
        bit ok;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        chk("model_sub",  ref_op(32'd5, 32'd3, 2'b00, 1'b0, 1'b0), {32'd2, 4'b0010});
        chk("model_rsc",  ref_op(32'd3, 32'd5, 2'b11, 1'b0, 1'b0), {32'd1, 4'b0010});
        chk("model_ovf",  ref_op(32'h8000_0000, 32'd1, 2'b00, 1'b0, 1'b0), {32'h7FFF_FFFF, 4'b0011});

        directed("sub_5_3",   32'd5,        32'd3,        2'b00, 1'b0, 32'd2,         4'b0010);
        directed("sub_0_1",   32'd0,        32'd1,        2'b00, 1'b0, 32'hFFFF_FFFF, 4'b1000);
        directed("sub_eq",    32'h1234,     32'h1234,     2'b00, 1'b0, 32'd0,         4'b0110);
        directed("sub_ovf",   32'h8000_0000, 32'd1,       2'b00, 1'b0, 32'h7FFF_FFFF, 4'b0011);
        directed("rsb_3_5",   32'd3,        32'd5,        2'b10, 1'b0, 32'd2,         4'b0010);
        directed("rsc_3_5",   32'd3,        32'd5,        2'b11, 1'b0, 32'd1,         4'b0010);
        directed("sbc_5_3",   32'd5,        32'd3,        2'b01, 1'b0, 32'd1,         4'b0010);
        directed("sbc_0_0",   32'd0,        32'd0,        2'b01, 1'b0, 32'hFFFF_FFFF, 4'b1000);
        directed("sbc_c1",    32'd5,        32'd3,        2'b01, 1'b1, 32'd2,         4'b0010);
`ifdef SUB_SATURATE_EN
        in_sat = 1'b1;
        directed("sat_neg",   32'h8000_0000, 32'd1,        2'b00, 1'b0, 32'h8000_0000, 4'b1011);
        directed("sat_pos",   32'h7FFF_FFFF, 32'hFFFF_FFFF, 2'b00, 1'b0, 32'h7FFF_FFFF, 4'b0001);
        in_sat = 1'b0;
`endif

        // Backpressure: six ops into depth 4, output held off for 4 cycles after first result.
        repeat (10) @(posedge clk);
        #1 start = xfer_cnt[0];
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    in_valid = 1'b1; in_a = $urandom; in_b = $urandom;
                    in_mode = 2'($urandom_range(0, 3)); in_cin = 1'($urandom_range(0, 1));
                    guard = 0;
                    do begin
                        @(negedge clk); #2;
                        ok = in_ready_w[0];
                        @(posedge clk); #1;
                        guard++;
                    end while (!ok && guard < 50);
                end
                in_valid = 1'b0;
            end
            begin
                for (int j = 0; j < 50; j++) begin
                    @(negedge clk);
                    if (out_valid_w[0]) break;
                end
                out_ready = 1'b0;
                #1;
                checks++;
                if (in_ready_w[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_in_ready got %b exp 0", in_ready_w[0]);
                end
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (xfer_cnt[0] - start != 6) begin
            errors++;
            $display("FAIL backpressure_count got %0d exp 6", xfer_cnt[0] - start);
        end

        // Reset with three ops in flight: none of them may ever emerge.
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_a = $urandom; in_b = $urandom; in_mode = 2'b00;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        c = xfer_cnt[0];
        repeat (15) @(posedge clk);
        #1;
        checks++;
        if (xfer_cnt[0] != c) begin
            errors++;
            $display("FAIL flush got %0d outputs exp 0", xfer_cnt[0] - c);
        end

        // Random traffic with random backpressure.
        repeat (400) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_a = pick(); in_b = pick();
            in_mode = 2'($urandom_range(0, 3)); in_cin = 1'($urandom_range(0, 1));
`ifdef SUB_SATURATE_EN
            in_sat = 1'($urandom_range(0, 1));
`endif
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) begin
            checks++;
            if (qlen[g] != 0) begin
                errors++;
                $display("FAIL drain inst %0d left %0d", g, qlen[g]);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
